crono_control: RTL and testbench
================================

Name: crono_control

Overview:
- Upstream control stage for the irrigation stopwatch (BCD MM:SS counter chain plus multiplexed 7-segment display).
- Turns raw push buttons and a forced-stop level from the irrigation logic into the stopwatch's timing and control signals:
  - a gated 1 Hz count strobe,
  - a free-running display-multiplex strobe,
  - a one-cycle clear pulse.
- Contains a run/pause/clear state machine, two button debouncers and two prescalers.

Parameters:
- TICK_DIV, 50000000: clk cycles per count strobe (1 Hz at 50 MHz).
- MUX_DIV, 50000: clk cycles per display-multiplex strobe (1 kHz).
- DB_CYC, 500000: cycles a synchronised button level must stay stable before it is accepted (10 ms).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_run  in  1  raw run/pause button, active-high, asynchronous to clk.
- btn_clr  in  1  raw clear button, active-high, asynchronous to clk.
- ext_stop  in  1  level from the irrigation logic (e.g. tank empty); forces a pause while high.
- sec_tick  out  1  one-cycle strobe that advances the seconds-units counter; only produced in RUNNING.
- mux_tick  out  1  one-cycle strobe that advances the display digit scan; always running.
- clr  out  1  one-cycle pulse that zeroes all four BCD counters.
- running  out  1  high while the state is RUNNING.
- state  out  2  IDLE=00, RUNNING=01, PAUSED=10.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: state=IDLE, sec_tick=0, mux_tick=0, clr=0, running=0.
  - Internals: both prescalers=0, synchroniser and debounce registers=0, debounced levels=0.
  - rst overrides every other input in that cycle, including mid-press and mid-second.
- Synchroniser: each button passes through a 2-FF synchroniser.
- Debouncer:
  - A counter runs while the synchronised level differs from the debounced level.
  - It resets to 0 whenever the two are equal.
  - When the count reaches DB_CYC-1, the debounced level takes the new value.
  - A press pulse (run_p / clr_p) is produced on the debounced 0->1 edge. Release produces nothing.
  - Press-to-pulse latency: 2 + DB_CYC + 1 cycles from the raw edge.
  - Glitches shorter than DB_CYC cycles are ignored.
- FSM transitions (evaluated once per cycle, in this priority order):
  - IDLE: clr_p -> IDLE with clr=1 next cycle. Otherwise run_p && !ext_stop -> RUNNING.
  - RUNNING: ext_stop=1 -> PAUSED (forced). Else run_p -> PAUSED. clr_p is ignored.
  - PAUSED: clr_p -> IDLE with clr=1 next cycle. Else run_p && !ext_stop -> RUNNING. run_p while ext_stop=1 is ignored.
  - run_p and clr_p in the same cycle: clr_p wins in IDLE and PAUSED; run_p wins in RUNNING.
  - The 2-bit state code 11 is illegal and recovers to IDLE on the next edge.
- Count prescaler (0..TICK_DIV-1):
  - Increments only while the state register is RUNNING.
  - Holds its value in PAUSED, so a resume completes the partial second.
  - Is set to 0 on any transition into IDLE.
  - sec_tick is registered: it is 1 in the cycle after the prescaler equals TICK_DIV-1 while the state is RUNNING. The prescaler wraps to 0 on that same edge.
  - If a pause and the terminal count coincide in one cycle, the strobe is still issued.
  - The first sec_tick after IDLE->RUNNING arrives exactly TICK_DIV cycles after running rises.
- Mux prescaler (0..MUX_DIV-1):
  - Free-running and unaffected by the FSM.
  - mux_tick is registered and is 1 for one cycle every MUX_DIV cycles.
  - The first mux_tick comes MUX_DIV cycles after rst is released.
- clr: registered, high for exactly one cycle, in the same cycle the state becomes IDLE; sec_tick is never 1 in that cycle.
- running: equals (state==RUNNING) and is registered with state.
- Counter widths: ceil(log2(max(DIV,2))) for each counter; all counters wrap modulo their divisor with no overflow.

Test Plan (TICK_DIV=10, MUX_DIV=4, DB_CYC=3):
- Reset/mux:
  - Stimulus: release rst, hold all inputs 0 for 20 cycles.
  - Required: state=00, sec_tick never 1, clr never 1; mux_tick high at cycles 4, 8, 12, 16, 20 only.
- Start and count:
  - Stimulus: btn_run high for 8 cycles.
  - Required: state=01 at 2+3+1+1 cycles after the edge; sec_tick at +10, +20, +30 cycles after running rises.
- Pause/resume preserving phase:
  - Stimulus: press run 4 cycles after a sec_tick, wait 25 cycles, press run again.
  - Required: state 01->10->01; the next sec_tick comes 6 cycles after running re-asserts.
- Forced stop:
  - Stimulus: in RUNNING, raise ext_stop; while it is high, press run.
  - Required: state=10 one cycle after ext_stop rises; the run press is ignored and the state stays 10.
- Clear:
  - Stimulus: press clr in RUNNING, then in PAUSED.
  - Required: in RUNNING nothing happens. In PAUSED, a single-cycle clr pulse coincides with state=00; the prescaler restarts, so the first sec_tick comes 10 cycles after the next start.
- Glitch and reset mid-operation:
  - Stimulus: a 2-cycle btn_run glitch; then rst for 1 cycle while RUNNING with the prescaler at 7.
  - Required: the glitch causes no transition. After rst, state=00, running=0, and no sec_tick is produced.

Source files
------------

// File: rtl/crono_control.sv
// crono_control: run/pause/clear sequencing for the irrigation stopwatch.
// Debounces the buttons and produces the count, display-scan and clear strobes.
module crono_control #(
  parameter int TICK_DIV = 50000000,
  parameter int MUX_DIV  = 50000,
  parameter int DB_CYC   = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_clr,
  input  logic       ext_stop,
  output logic       sec_tick,
  output logic       mux_tick,
  output logic       clr,
  output logic       running,
  output logic [1:0] state
);

  localparam int TW = $clog2(TICK_DIV < 2 ? 2 : TICK_DIV);
  localparam int MW = $clog2(MUX_DIV < 2 ? 2 : MUX_DIV);
  localparam int DW = $clog2(DB_CYC < 2 ? 2 : DB_CYC);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    BAD   = 2'b11
  } state_e;

  // bit 0 = run button, bit 1 = clear button
  logic [1:0]         btn;
  logic [1:0]         s1_q, s2_q;
  logic [1:0]         db_q, dbp_q, prs_q;
  logic [1:0][DW-1:0] db_cnt_q;

  assign btn = {btn_clr, btn_run};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      db_q     <= '0;
      dbp_q    <= '0;
      prs_q    <= '0;
      db_cnt_q <= '0;
    end else begin
      s1_q  <= btn;
      s2_q  <= s1_q;
      dbp_q <= db_q;
      prs_q <= db_q & ~dbp_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DW'(DB_CYC - 1)) begin
          db_cnt_q[i] <= '0;
          db_q[i]     <= s2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  logic run_p, clr_p;
  assign run_p = prs_q[0];
  assign clr_p = prs_q[1];

  state_e  state_q, state_d;
  logic    clr_q, clr_d;
  logic    running_q, sec_q;
  logic [TW-1:0] tick_cnt_q;
  logic    tick_end;

  assign tick_end = (tick_cnt_q == TW'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_p) clr_d = 1'b1;
        else if (run_p && !ext_stop) state_d = RUN;
      end
      RUN: begin
        if (ext_stop || run_p) state_d = PAUSE;
      end
      PAUSE: begin
        if (clr_p) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (run_p && !ext_stop) begin
          state_d = RUN;
        end
      end
      BAD: state_d = IDLE;
    endcase
  end

  // strobe keys off the current state so a pause on the terminal count still ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clr_q      <= 1'b0;
      running_q  <= 1'b0;
      sec_q      <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      running_q <= (state_d == RUN);
      sec_q     <= (state_q == RUN) && tick_end;
      if (state_d == IDLE) begin
        tick_cnt_q <= '0;
      end else if (state_q == RUN) begin
        tick_cnt_q <= tick_end ? '0 : tick_cnt_q + TW'(1);
      end
    end
  end

  logic [MW-1:0] mux_cnt_q;
  logic          mux_q;
  logic          mux_end;

  assign mux_end = (mux_cnt_q == MW'(MUX_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_cnt_q <= '0;
      mux_q     <= 1'b0;
    end else begin
      mux_q     <= mux_end;
      mux_cnt_q <= mux_end ? '0 : mux_cnt_q + MW'(1);
    end
  end

  assign sec_tick = sec_q;
  assign mux_tick = mux_q;
  assign clr      = clr_q;
  assign running  = running_q;
  assign state    = state_q;

endmodule

// File: tb/tb_crono_control.sv
// tb_crono_control: directed scenarios plus random button/stop traffic,
// every cycle checked against a rule-level model of the control stage.
module tb_crono_control;

  localparam int TD = 10;
  localparam int MD = 4;
  localparam int DB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_run = 1'b0;
  logic       btn_clr = 1'b0;
  logic       ext_stop = 1'b0;
  logic       sec_tick, mux_tick, clr, running;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  crono_control #(
    .TICK_DIV(TD),
    .MUX_DIV (MD),
    .DB_CYC  (DB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_run (btn_run),
    .btn_clr (btn_clr),
    .ext_stop(ext_stop),
    .sec_tick(sec_tick),
    .mux_tick(mux_tick),
    .clr     (clr),
    .running (running),
    .state   (state)
  );

  always #5 clk = ~clk;

  logic [5:0] dut_vec;
  assign dut_vec = {state, sec_tick, mux_tick, clr, running};

  // model: buttons seen two cycles late, accepted after DB steady-different
  // cycles, acted on two cycles after acceptance; seconds = RUNNING cycles / TD
  logic [1:0] m_st = 2'b00;
  bit   m_sec, m_mux, m_clr, m_run;
  int   m_phase, m_cyc;
  bit   hist [2][2];
  bit   dbl [2];
  int   dlen [2];
  bit   pp [2][2];
  logic [5:0] m_vec = '0;

  task automatic model_step();
    bit raw [2];
    bit eff [2];
    bit sy;
    logic [1:0] nst;
    raw[0] = btn_run;
    raw[1] = btn_clr;
    if (rst) begin
      m_st = 2'b00; m_sec = 0; m_mux = 0; m_clr = 0; m_run = 0;
      m_phase = 0; m_cyc = 0;
      for (int b = 0; b < 2; b++) begin
        hist[b][0] = 0; hist[b][1] = 0; dbl[b] = 0; dlen[b] = 0;
        pp[b][0] = 0; pp[b][1] = 0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        eff[b] = pp[b][1];
        pp[b][1] = pp[b][0];
        pp[b][0] = 0;
        sy = hist[b][1];
        hist[b][1] = hist[b][0];
        hist[b][0] = raw[b];
        if (sy != dbl[b]) begin
          dlen[b]++;
          if (dlen[b] == DB) begin
            dbl[b] = sy;
            dlen[b] = 0;
            pp[b][0] = sy;
          end
        end else begin
          dlen[b] = 0;
        end
      end
      nst = m_st;
      m_clr = 0;
      case (m_st)
        2'b00: if (eff[1]) m_clr = 1;
               else if (eff[0] && !ext_stop) nst = 2'b01;
        2'b01: if (ext_stop || eff[0]) nst = 2'b10;
        2'b10: if (eff[1]) begin nst = 2'b00; m_clr = 1; end
               else if (eff[0] && !ext_stop) nst = 2'b01;
        default: nst = 2'b00;
      endcase
      m_sec = 0;
      if (m_st == 2'b01) begin
        m_phase++;
        if (m_phase == TD) begin m_sec = 1; m_phase = 0; end
      end
      if (nst == 2'b00) m_phase = 0;
      m_st = nst;
      m_run = (nst == 2'b01);
      m_cyc++;
      m_mux = (m_cyc % MD == 0);
    end
    m_vec = {m_st, m_sec, m_mux, m_clr, m_run};
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic test_reset();
    logic [19:0] mask = '0;
    bit noisy = 0;
    rst = 1; btn_run = 0; btn_clr = 0; ext_stop = 0;
    @(negedge clk);
    n_cmp++;
    if (dut_vec !== 6'b0) begin
      n_bad++; $display("FAIL reset_vals got=%b want=000000", dut_vec);
    end
    rst = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== m_vec) begin
        n_bad++; $display("FAIL reset_model k=%0d got=%b want=%b", k, dut_vec, m_vec);
      end
      mask[k-1] = mux_tick;
      if (state !== 2'b00 || sec_tick !== 1'b0 || clr !== 1'b0) noisy = 1;
    end
    n_cmp++;
    if (mask !== 20'h88888) begin
      n_bad++; $display("FAIL mux_pattern got=%h want=88888", mask);
    end
    n_cmp++;
    if (noisy) begin
      n_bad++; $display("FAIL idle_quiet got=activity want=none");
    end
  endtask

  task automatic test_start_count();
    int rise = -1;
    int ticks[$];
    btn_run = 1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== m_vec) begin
        n_bad++; $display("FAIL start_model k=%0d got=%b want=%b", k, dut_vec, m_vec);
      end
      if (k == 8) btn_run = 0;
      if (running === 1'b1 && rise < 0) rise = k;
      if (sec_tick === 1'b1) ticks.push_back(k);
    end
    n_cmp++;
    if (rise != 7) begin
      n_bad++; $display("FAIL start_latency got=%0d want=7", rise);
    end
    n_cmp++;
    if (ticks.size() != 3 || ticks[0] != 17 || ticks[1] != 27 || ticks[2] != 37) begin
      n_bad++; $display("FAIL tick_times got=%p want=17,27,37", ticks);
    end
  endtask

  task automatic test_pause_resume();
    int pj = -1, rj = -1, sj = -1;
    bit got = 0;
    for (int i = 0; i < 3 * TD && !got; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== m_vec) begin
        n_bad++; $display("FAIL pause_model_w got=%b want=%b", dut_vec, m_vec);
      end
      if (sec_tick === 1'b1) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++; $display("FAIL pause_wait got=no_tick want=tick within %0d", 3 * TD);
      return;
    end
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== m_vec) begin
        n_bad++; $display("FAIL pause_model j=%0d got=%b want=%b", j, dut_vec, m_vec);
      end
      if (state === 2'b10 && pj < 0) pj = j;
      if (pj > 0 && running === 1'b1 && rj < 0) rj = j;
      if (rj > 0 && sec_tick === 1'b1 && sj < 0) sj = j;
      if (j == 7 || j == 39) btn_run = 1;
      if (j == 11 || j == 43) btn_run = 0;
    end
    n_cmp++;
    if (pj != 14) begin
      n_bad++; $display("FAIL pause_time got=%0d want=14", pj);
    end
    n_cmp++;
    if (rj != 46) begin
      n_bad++; $display("FAIL resume_time got=%0d want=46", rj);
    end
    n_cmp++;
    if (sj - rj != 6) begin
      n_bad++; $display("FAIL resume_phase got=%0d want=6", sj - rj);
    end
  endtask

  task automatic test_forced_stop();
    bit moved = 0;
    ext_stop = 1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== m_vec) begin
        n_bad++; $display("FAIL stop_model k=%0d got=%b want=%b", k, dut_vec, m_vec);
      end
      if (k == 1) begin
        n_cmp++;
        if (state !== 2'b10) begin
          n_bad++; $display("FAIL forced_pause got=%b want=10", state);
        end
      end else if (state !== 2'b10) begin
        moved = 1;
      end
      if (k == 2) btn_run = 1;
      if (k == 6) btn_run = 0;
      if (k == 20) ext_stop = 0;
    end
    n_cmp++;
    if (moved) begin
      n_bad++; $display("FAIL forced_hold got=left_paused want=stay_10");
    end
  endtask

  task automatic test_clear();
    logic [1:0] st [0:100];
    bit ck [0:100];
    int nclr = 0, fs = -1;
    btn_run = 1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== m_vec) begin
        n_bad++; $display("FAIL clear_model k=%0d got=%b want=%b", k, dut_vec, m_vec);
      end
      st[k] = state;
      ck[k] = (clr === 1'b1);
      if (clr === 1'b1) nclr++;
      if (k > 62 && fs < 0 && sec_tick === 1'b1) fs = k;
      case (k)
        4:  btn_run = 0;
        10: btn_clr = 1;
        14: btn_clr = 0;
        25: begin btn_run = 1; btn_clr = 1; end
        29: begin btn_run = 0; btn_clr = 0; end
        40: btn_clr = 1;
        44: btn_clr = 0;
        55: btn_run = 1;
        59: btn_run = 0;
        75: begin btn_run = 1; btn_clr = 1; end
        79: begin btn_run = 0; btn_clr = 0; end
        90: begin btn_run = 1; btn_clr = 1; end
        94: begin btn_run = 0; btn_clr = 0; end
        default: ;
      endcase
    end
    n_cmp++;
    if (st[24] !== 2'b01) begin
      n_bad++; $display("FAIL clr_in_run got=%b want=01", st[24]);
    end
    n_cmp++;
    if (st[32] !== 2'b10) begin
      n_bad++; $display("FAIL both_in_run got=%b want=10", st[32]);
    end
    n_cmp++;
    if (st[46] !== 2'b10 || st[47] !== 2'b00) begin
      n_bad++; $display("FAIL clr_in_pause got=%b,%b want=10,00", st[46], st[47]);
    end
    n_cmp++;
    if (!(nclr == 2 && ck[47] && ck[97])) begin
      n_bad++; $display("FAIL clr_pulses got=%0d pulses want=2 at 47,97", nclr);
    end
    n_cmp++;
    if (fs != 72) begin
      n_bad++; $display("FAIL restart_tick got=%0d want=72", fs);
    end
    n_cmp++;
    if (st[82] !== 2'b10 || st[97] !== 2'b00) begin
      n_bad++; $display("FAIL both_prio got=%b,%b want=10,00", st[82], st[97]);
    end
  endtask

  task automatic test_glitch_reset();
    bit moved = 0, noisy = 0;
    int fm = -1;
    btn_run = 1;
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== m_vec) begin
        n_bad++; $display("FAIL glitch_model k=%0d got=%b want=%b", k, dut_vec, m_vec);
      end
      if (k == 2) btn_run = 0;
      if (k <= 20 && state !== 2'b00) moved = 1;
      if (k == 20) btn_run = 1;
      if (k == 24) btn_run = 0;
      if (k == 27) begin
        n_cmp++;
        if (running !== 1'b1) begin
          n_bad++; $display("FAIL restart_run got=%b want=1", running);
        end
      end
      if (k == 34) rst = 1;
      if (k == 35) begin
        n_cmp++;
        if (dut_vec !== 6'b0) begin
          n_bad++; $display("FAIL mid_reset got=%b want=000000", dut_vec);
        end
        rst = 0;
      end
      if (k > 35 && (sec_tick !== 1'b0 || running !== 1'b0 || state !== 2'b00)) noisy = 1;
      if (k > 35 && fm < 0 && mux_tick === 1'b1) fm = k;
    end
    n_cmp++;
    if (moved) begin
      n_bad++; $display("FAIL glitch got=transition want=none");
    end
    n_cmp++;
    if (noisy) begin
      n_bad++; $display("FAIL post_reset got=activity want=idle");
    end
    n_cmp++;
    if (fm != 39) begin
      n_bad++; $display("FAIL mux_restart got=%0d want=39", fm);
    end
  endtask

  task automatic test_random();
    int hr = 1, hc = 1, he = 1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== m_vec) begin
        n_bad++; $display("FAIL random k=%0d got=%b want=%b", k, dut_vec, m_vec);
      end
      rst = ($urandom_range(0, 399) == 0);
      hr--;
      if (hr <= 0) begin
        btn_run = ~btn_run;
        hr = $urandom_range(1, 12);
      end
      hc--;
      if (hc <= 0) begin
        btn_clr = ~btn_clr;
        hc = btn_clr ? $urandom_range(1, 8) : $urandom_range(20, 120);
      end
      he--;
      if (he <= 0) begin
        ext_stop = ~ext_stop;
        he = ext_stop ? $urandom_range(1, 30) : $urandom_range(20, 150);
      end
    end
    rst = 0; btn_run = 0; btn_clr = 0; ext_stop = 0;
  endtask

  initial begin
    test_reset();
    test_start_count();
    test_pause_resume();
    test_forced_stop();
    test_clear();
    test_glitch_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
